// File: rtl/fsm_stim_checker_pkg.sv
// Shared definitions for the FSM stimulus/response checker: controller
// state encoding and the packing of one step-table entry.
// Entry layout, MSB to LSB: {ab[1:0], exp_x[DATA_W-1:0], exp_y[DATA_W-1:0]}.
package fsm_stim_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } stim_state_e;

  localparam int unsigned AB_W = 2;

  // Total width of one table entry for a given response width.
  function automatic int unsigned entry_w(input int unsigned data_w);
    return AB_W + (2 * data_w);
  endfunction

  // LSB position of the expected-y field.
  function automatic int unsigned y_lsb(input int unsigned data_w);
    return 0;
  endfunction

  // LSB position of the expected-x field.
  function automatic int unsigned x_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  // LSB position of the {a,b} stimulus field.
  function automatic int unsigned ab_lsb(input int unsigned data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/fsm_stim_table.sv
// Step table for the stimulus checker: 2**ADDR_W entries of
// {ab, exp_x, exp_y}. Synchronous write, asynchronous read. Contents are
// deliberately not reset so a programmed test survives a controller reset.
module fsm_stim_table
  import fsm_stim_checker_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  localparam int unsigned ENTRY_W = entry_w(DATA_W)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0]  wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [ENTRY_W-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [ENTRY_W-1:0] mem_r [DEPTH];

  // Table write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Combinational read of the entry selected by the running step index.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/fsm_stim_checker.sv
// Stimulus/response partner for a two-input/two-output FSM under test.
// Walks a programmed step table, drives {a,b}, waits SETTLE cycles, compares
// x/y with the expected values and reports pass, error count and first
// failing step. Each step costs SETTLE+2 cycles (APPLY, WAIT x SETTLE, CHECK).
// Build option: define STIM_STOP_ON_ERR_EN to halt in FAIL on the first
// mismatch, holding the failing stimulus on a_o/b_o for probing.
module fsm_stim_checker
  import fsm_stim_checker_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [1:0]        cfg_ab,
  input  logic [DATA_W-1:0] cfg_x,
  input  logic [DATA_W-1:0] cfg_y,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              start,
  output logic              a_o,
  output logic              b_o,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] err_step
);

  localparam int unsigned ENTRY_W = entry_w(DATA_W);
  localparam int unsigned LW      = ADDR_W + 1;
  localparam int unsigned AB_LSB  = ab_lsb(DATA_W);
  localparam int unsigned X_LSB   = x_lsb(DATA_W);
  localparam int unsigned Y_LSB   = y_lsb(DATA_W);
  // WAIT counts down from SETTLE-1 so that WAIT lasts exactly SETTLE cycles.
  localparam logic [3:0]  WAIT_LOAD = 4'((SETTLE > 0) ? (SETTLE - 1) : 0);

  stim_state_e       state_r, state_s;
  logic [ADDR_W-1:0] idx_r, idx_s;
  logic [LW-1:0]     len_r, len_s;
  logic [3:0]        wait_r, wait_s;
  logic [1:0]        ab_r, ab_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              pass_r, pass_s;
  logic [LW-1:0]     err_cnt_r, err_cnt_s;
  logic [ADDR_W-1:0] err_step_r, err_step_s;

  logic [ENTRY_W-1:0] entry_s;
  logic [1:0]         exp_ab_s;
  logic [DATA_W-1:0]  exp_x_s;
  logic [DATA_W-1:0]  exp_y_s;
  logic               mismatch_s;
  logic               last_s;
  logic [LW-1:0]      err_inc_s;
  logic [LW-1:0]      cnt_chk_s;
  logic               tbl_we_s;

  // Writes are only accepted while no run is in progress.
  assign tbl_we_s = cfg_we & ~busy_r;

  fsm_stim_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk   (clk),
    .we    (tbl_we_s),
    .waddr (cfg_addr),
    .wdata ({cfg_ab, cfg_x, cfg_y}),
    .raddr (idx_r),
    .rdata (entry_s)
  );

  // Unpack the current step's entry and evaluate the response.
  always_comb begin
    exp_ab_s   = entry_s[AB_LSB +: 2];
    exp_x_s    = entry_s[X_LSB +: DATA_W];
    exp_y_s    = entry_s[Y_LSB +: DATA_W];
    mismatch_s = (x_i != exp_x_s) || (y_i != exp_y_s);
    last_s     = ({1'b0, idx_r} == (len_r - LW'(1)));
    err_inc_s  = (err_cnt_r == {LW{1'b1}}) ? err_cnt_r : (err_cnt_r + LW'(1));
    cnt_chk_s  = mismatch_s ? err_inc_s : err_cnt_r;
  end

  // Next-state and next-output logic of the run controller.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    len_s      = len_r;
    wait_s     = wait_r;
    ab_s       = ab_r;
    busy_s     = busy_r;
    done_s     = done_r;
    pass_s     = pass_r;
    err_cnt_s  = err_cnt_r;
    err_step_s = err_step_r;

    case (state_r)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          len_s      = cfg_len;
          idx_s      = {ADDR_W{1'b0}};
          err_cnt_s  = {LW{1'b0}};
          err_step_s = {ADDR_W{1'b0}};
          ab_s       = 2'b00;
          if (cfg_len == {LW{1'b0}}) begin
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = 1'b1;
          end else begin
            state_s = ST_APPLY;
            busy_s  = 1'b1;
            done_s  = 1'b0;
            pass_s  = 1'b0;
          end
        end else begin
          state_s = state_r;
        end
      end

      ST_APPLY: begin
        ab_s = exp_ab_s;
        if (SETTLE > 0) begin
          state_s = ST_WAIT;
          wait_s  = WAIT_LOAD;
        end else begin
          state_s = ST_CHECK;
        end
      end

      ST_WAIT: begin
        if (wait_r == 4'd0) begin
          state_s = ST_CHECK;
        end else begin
          wait_s = wait_r - 4'd1;
        end
      end

      ST_CHECK: begin
        err_cnt_s = cnt_chk_s;
        if (mismatch_s && (err_cnt_r == {LW{1'b0}})) begin
          err_step_s = idx_r;
        end else begin
          err_step_s = err_step_r;
        end
`ifdef STIM_STOP_ON_ERR_EN
        if (mismatch_s) begin
          // Freeze with the failing stimulus still applied.
          state_s = ST_FAIL;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = 1'b0;
        end else if (last_s) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (cnt_chk_s == {LW{1'b0}});
          ab_s    = 2'b00;
        end else begin
          state_s = ST_APPLY;
          idx_s   = idx_r + ADDR_W'(1);
        end
`else
        if (last_s) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (cnt_chk_s == {LW{1'b0}});
          ab_s    = 2'b00;
        end else begin
          state_s = ST_APPLY;
          idx_s   = idx_r + ADDR_W'(1);
        end
`endif
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
        ab_s    = 2'b00;
      end
    endcase
  end

  // Controller state and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= {ADDR_W{1'b0}};
      len_r      <= {LW{1'b0}};
      wait_r     <= 4'd0;
      ab_r       <= 2'b00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      err_cnt_r  <= {LW{1'b0}};
      err_step_r <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      len_r      <= len_s;
      wait_r     <= wait_s;
      ab_r       <= ab_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      pass_r     <= pass_s;
      err_cnt_r  <= err_cnt_s;
      err_step_r <= err_step_s;
    end
  end

  assign a_o      = ab_r[1];
  assign b_o      = ab_r[0];
  assign busy     = busy_r;
  assign done     = done_r;
  assign pass     = pass_r;
  assign err_cnt  = err_cnt_r;
  assign err_step = err_step_r;

endmodule
